jt900h_memarb: RTL and testbench

Two-port arbiter that shares the single 16-bit memory bus (24-bit byte address, 2-bit byte-lane write enable) between the jt900h CPU core and the micro-DMA engine. It sits between both requesters and the external RAM/ROM port, sequences each access through a small FSM with a programmable read latency, and returns data with a one-cycle ready pulse. DMA steals bus cycles by priority, bounded by a fairness limit so the CPU is never starved.

---
 rtl/jt900h_memarb_pkg.sv | 22 ++
 rtl/jt900h_memarb_pick.sv | 21 ++
 rtl/jt900h_memarb.sv | 139 +++++++++++++
 tb/tb_jt900h_memarb.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jt900h_memarb_pkg.sv
// Shared types and constants for the jt900h CPU / micro-DMA memory arbiter.
// State encodings, grant bit positions and counter widths live here.
package jt900h_memarb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam int GNT_CPU = 0;
    localparam int GNT_DMA = 1;
    localparam logic [1:0] GNT_NONE = 2'b00;

    localparam int LAT_W    = 3;
    localparam int STREAK_W = 4;

    function automatic logic is_write(input logic [1:0] we);
        return we != 2'b00;
    endfunction

endpackage

// File: rtl/jt900h_memarb_pick.sv
// Combinational requester selection: DMA has priority unless it has already
// taken the bus LOCKMAX times in a row while the CPU was waiting.
module jt900h_memarb_pick
    import jt900h_memarb_pkg::*;
(
    input  logic       cpu_req,
    input  logic       dma_req,
    input  logic       at_limit,
    output logic [1:0] grant
);

    always_comb begin
        grant = GNT_NONE;
        if (dma_req && !(cpu_req && at_limit)) begin
            grant[GNT_DMA] = 1'b1;
        end else if (cpu_req) begin
            grant[GNT_CPU] = 1'b1;
        end
    end

endmodule

// File: rtl/jt900h_memarb.sv
// Shares one 16-bit memory bus between the jt900h CPU and the micro-DMA engine.
// Each access runs IDLE -> ACCESS -> DONE; reads wait MEMLAT cen-qualified cycles.
module jt900h_memarb
    import jt900h_memarb_pkg::*;
#(
    parameter int MEMLAT  = 1,
    parameter int LOCKMAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic        cpu_req,
    input  logic [23:0] cpu_addr,
    input  logic [1:0]  cpu_we,
    input  logic [15:0] cpu_dout,
    output logic [15:0] cpu_din,
    output logic        cpu_rdy,
    input  logic        dma_req,
    input  logic [23:0] dma_addr,
    input  logic [1:0]  dma_we,
    input  logic [15:0] dma_dout,
    output logic [15:0] dma_din,
    output logic        dma_rdy,
    output logic [23:0] mem_addr,
    output logic [15:0] mem_dout,
    input  logic [15:0] mem_din,
    output logic [1:0]  mem_we,
    output logic        mem_cs,
    output logic [1:0]  gnt
);

    state_t                state_reg;
    logic [LAT_W-1:0]      lat_reg;
    logic [STREAK_W-1:0]   streak_reg;
    logic [1:0]            gnt_reg;
    logic [23:0]           addr_reg;
    logic [15:0]           dout_reg;
    logic [1:0]            we_reg;
    logic                  cs_reg;
    logic                  cpu_rdy_reg;
    logic                  dma_rdy_reg;
    logic [15:0]           cpu_din_reg;
    logic [15:0]           dma_din_reg;

    logic [1:0]            pick;
    logic                  at_limit;

    assign at_limit = (streak_reg == STREAK_W'(LOCKMAX));

    jt900h_memarb_pick u_pick (
        .cpu_req  (cpu_req),
        .dma_req  (dma_req),
        .at_limit (at_limit),
        .grant    (pick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= ST_IDLE;
            lat_reg     <= '0;
            streak_reg  <= '0;
            gnt_reg     <= GNT_NONE;
            addr_reg    <= '0;
            dout_reg    <= '0;
            we_reg      <= 2'b00;
            cs_reg      <= 1'b0;
            cpu_rdy_reg <= 1'b0;
            dma_rdy_reg <= 1'b0;
            cpu_din_reg <= '0;
            dma_din_reg <= '0;
        end else if (cen) begin
            case (state_reg)
                ST_IDLE: begin
                    if (pick != GNT_NONE) begin
                        gnt_reg   <= pick;
                        cs_reg    <= 1'b1;
                        lat_reg   <= LAT_W'(MEMLAT);
                        state_reg <= ST_ACCESS;
                        if (pick[GNT_DMA]) begin
                            addr_reg <= dma_addr;
                            dout_reg <= dma_dout;
                            we_reg   <= dma_we;
                            // The streak only measures how long the CPU has been kept waiting
                            if (!cpu_req) begin
                                streak_reg <= '0;
                            end else if (!at_limit) begin
                                streak_reg <= streak_reg + STREAK_W'(1);
                            end
                        end else begin
                            addr_reg   <= cpu_addr;
                            dout_reg   <= cpu_dout;
                            we_reg     <= cpu_we;
                            streak_reg <= '0;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (is_write(we_reg) || lat_reg == '0) begin
                        if (!is_write(we_reg)) begin
                            if (gnt_reg[GNT_CPU]) begin
                                cpu_din_reg <= mem_din;
                            end else begin
                                dma_din_reg <= mem_din;
                            end
                        end
                        cpu_rdy_reg <= gnt_reg[GNT_CPU];
                        dma_rdy_reg <= gnt_reg[GNT_DMA];
                        we_reg      <= 2'b00;
                        cs_reg      <= 1'b0;
                        gnt_reg     <= GNT_NONE;
                        state_reg   <= ST_DONE;
                    end else begin
                        lat_reg <= lat_reg - LAT_W'(1);
                    end
                end
                ST_DONE: begin
                    cpu_rdy_reg <= 1'b0;
                    dma_rdy_reg <= 1'b0;
                    state_reg   <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // Strobes are held in their registers while cen is low and only shown on a cen-high cycle
    assign mem_we   = we_reg & {2{cen}};
    assign cpu_rdy  = cpu_rdy_reg & cen;
    assign dma_rdy  = dma_rdy_reg & cen;
    assign mem_addr = addr_reg;
    assign mem_dout = dout_reg;
    assign mem_cs   = cs_reg;
    assign gnt      = gnt_reg;
    assign cpu_din  = cpu_din_reg;
    assign dma_din  = dma_din_reg;

endmodule

// File: tb/tb_jt900h_memarb.sv
// Self-checking bench for jt900h_memarb: directed timing cases plus a randomized
// two-requester run scored against a transaction-level arbitration model.
module tb_jt900h_memarb;

    localparam int MEMLAT  = 1;
    localparam int LOCKMAX = 4;
    localparam int N_RUN   = 800;

    logic        clk = 1'b0;
    logic        rst;
    logic        cen;
    logic        cpu_req;
    logic [23:0] cpu_addr;
    logic [1:0]  cpu_we;
    logic [15:0] cpu_dout;
    logic [15:0] cpu_din;
    logic        cpu_rdy;
    logic        dma_req;
    logic [23:0] dma_addr;
    logic [1:0]  dma_we;
    logic [15:0] dma_dout;
    logic [15:0] dma_din;
    logic        dma_rdy;
    logic [23:0] mem_addr;
    logic [15:0] mem_dout;
    logic [15:0] mem_din;
    logic [1:0]  mem_we;
    logic        mem_cs;
    logic [1:0]  gnt;

    always #5 clk = ~clk;

    jt900h_memarb #(.MEMLAT(MEMLAT), .LOCKMAX(LOCKMAX)) dut (
        .clk      (clk),
        .rst      (rst),
        .cen      (cen),
        .cpu_req  (cpu_req),
        .cpu_addr (cpu_addr),
        .cpu_we   (cpu_we),
        .cpu_dout (cpu_dout),
        .cpu_din  (cpu_din),
        .cpu_rdy  (cpu_rdy),
        .dma_req  (dma_req),
        .dma_addr (dma_addr),
        .dma_we   (dma_we),
        .dma_dout (dma_dout),
        .dma_din  (dma_din),
        .dma_rdy  (dma_rdy),
        .mem_addr (mem_addr),
        .mem_dout (mem_dout),
        .mem_din  (mem_din),
        .mem_we   (mem_we),
        .mem_cs   (mem_cs),
        .gnt      (gnt)
    );

    // Memory contents as a pure function of the address
    function automatic logic [15:0] mem_word(input logic [23:0] a);
        if (a == 24'h000802) return 16'h01FE;
        return a[15:0] ^ {a[23:16], a[7:0]} ^ 16'hC35A;
    endfunction

    assign mem_din = mem_word(mem_addr);

    // Winner given the request levels at the pick edge and how many DMA grants in a row the CPU has waited through
    function automatic logic [1:0] want_gnt(input logic c, input logic d, input int run);
        if (d && !(c && run >= LOCKMAX)) return 2'b10;
        if (c) return 2'b01;
        return 2'b00;
    endfunction

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic        c_act, d_act, c_fin, d_fin;
    logic [23:0] c_a, d_a;
    logic [1:0]  c_w, d_w;
    logic [15:0] c_o, d_o, c_dm, d_dm;
    int          c_age, d_age, run, owner, we_cnt;
    logic        e_c, e_d, e_cen;
    logic [1:0]  prev_gnt, exp_g;
    int          n_gr, last_t, c_grants, n_rdy, r0, r1, acc_hi;
    logic        got;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; cen = 1'b1;
        cpu_req = 1'b0; cpu_addr = '0; cpu_we = '0; cpu_dout = '0;
        dma_req = 1'b0; dma_addr = '0; dma_we = '0; dma_dout = '0;
        repeat (2) tick();

        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_dout", 32'(mem_dout), 0);
        chk("rst_mem_we",   32'(mem_we), 0);
        chk("rst_mem_cs",   32'(mem_cs), 0);
        chk("rst_gnt",      32'(gnt), 0);
        chk("rst_rdy",      32'({cpu_rdy, dma_rdy}), 0);
        chk("rst_cpu_din",  32'(cpu_din), 0);
        chk("rst_dma_din",  32'(dma_din), 0);
        rst = 1'b1;
        tick();

        // CPU read with latency
        cpu_addr = 24'h000802; cpu_we = 2'b00; cpu_req = 1'b1;
        for (int k = 1; k <= MEMLAT + 1; k++) begin
            tick();
            chk("rd_gnt", 32'(gnt), 32'(2'b01));
            chk("rd_cs", 32'(mem_cs), 1);
            chk("rd_addr", 32'(mem_addr), 32'(24'h000802));
            chk("rd_rdy_early", 32'(cpu_rdy), 0);
            chk("rd_we", 32'(mem_we), 0);
        end
        tick();
        chk("rd_rdy", 32'(cpu_rdy), 1);
        chk("rd_din", 32'(cpu_din), 32'(16'h01FE));
        chk("rd_dma_din_keep", 32'(dma_din), 0);
        chk("rd_gnt_done", 32'(gnt), 0);
        $display("cpu read  addr=000802 data=%04h", cpu_din);
        cpu_req = 1'b0;
        tick();
        chk("rd_rdy_pulse", 32'(cpu_rdy), 0);
        chk("rd_din_hold", 32'(cpu_din), 32'(16'h01FE));

        // DMA write, upper lane
        dma_addr = 24'h000FFF; dma_we = 2'b10; dma_dout = 16'hABCD; dma_req = 1'b1;
        tick();
        chk("wr_we", 32'(mem_we), 32'(2'b10));
        chk("wr_dout", 32'(mem_dout), 32'(16'hABCD));
        chk("wr_addr", 32'(mem_addr), 32'(24'h000FFF));
        chk("wr_gnt", 32'(gnt), 32'(2'b10));
        tick();
        chk("wr_we_once", 32'(mem_we), 0);
        chk("wr_rdy", 32'(dma_rdy), 1);
        chk("wr_cpu_rdy", 32'(cpu_rdy), 0);
        chk("wr_dma_din_keep", 32'(dma_din), 0);
        chk("wr_cpu_din_keep", 32'(cpu_din), 32'(16'h01FE));
        $display("dma write addr=000FFF data=ABCD we=10");
        dma_req = 1'b0;
        tick();
        chk("wr_rdy_pulse", 32'(dma_rdy), 0);

        // Both requesting continuously: fairness pattern
        cpu_addr = 24'h001000; cpu_we = 2'b01; cpu_dout = 16'h1111;
        dma_addr = 24'h002000; dma_we = 2'b11; dma_dout = 16'h2222;
        cpu_req = 1'b1; dma_req = 1'b1;
        run = 0; n_gr = 0; last_t = 0; c_grants = 0; prev_gnt = 2'b00;
        for (int t = 0; t < 100 && n_gr < 10; t++) begin
            tick();
            if (gnt != 2'b00 && prev_gnt == 2'b00) begin
                exp_g = want_gnt(1'b1, 1'b1, run);
                chk("seq_pick", 32'(gnt), 32'(exp_g));
                if (n_gr > 0) chk("seq_gap", 32'(t - last_t), 3);
                last_t = t;
                n_gr++;
                if (exp_g == 2'b01) begin
                    run = 0;
                    c_grants++;
                end else begin
                    run++;
                end
                $display("grant %0d -> %s", n_gr, (gnt == 2'b01) ? "C" : "D");
            end
            prev_gnt = gnt;
        end
        chk("seq_count", 32'(n_gr), 10);
        chk("seq_cpu_grants", 32'(c_grants), 2);
        cpu_req = 1'b0; dma_req = 1'b0;
        repeat (4) tick();

        // CPU holds request: two separate writes
        cpu_addr = 24'h000100; cpu_we = 2'b01; cpu_dout = 16'h5A5A; cpu_req = 1'b1;
        n_rdy = 0; r0 = 0; r1 = 0;
        for (int t = 0; t < 40 && n_rdy < 2; t++) begin
            tick();
            if (cpu_rdy) begin
                if (n_rdy == 0) r0 = t; else r1 = t;
                n_rdy++;
                $display("cpu write addr=000100 data=5A5A we=01 (hold %0d)", n_rdy);
                if (n_rdy == 2) cpu_req = 1'b0;
            end
        end
        chk("hold_rdy_count", 32'(n_rdy), 2);
        chk("hold_rdy_gap", 32'(r1 - r0), 3);
        repeat (3) begin
            tick();
            chk("hold_no_extra", 32'(cpu_rdy), 0);
        end

        // cen toggling during a read
        cpu_addr = 24'h3C0A16; cpu_we = 2'b00; cpu_req = 1'b1; cen = 1'b1;
        got = 1'b0; acc_hi = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(posedge clk); #1;
            cen = ~cen;
            @(negedge clk);
            chk("cen_we", 32'(mem_we), 0);
            if (!cen) chk("cen_rdy_lo", 32'(cpu_rdy), 0);
            if (cen && gnt == 2'b01) acc_hi++;
            if (cpu_rdy) begin
                got = 1'b1;
                chk("cen_rdy_hi", 32'(cen), 1);
                chk("cen_din", 32'(cpu_din), 32'(mem_word(24'h3C0A16)));
                $display("cpu read  addr=3C0A16 data=%04h (cen toggling)", cpu_din);
            end
        end
        chk("cen_done", 32'(got), 1);
        chk("cen_access_cycles", 32'(acc_hi), MEMLAT + 1);
        @(posedge clk); #1;
        cpu_req = 1'b0; cen = 1'b1;
        @(negedge clk);
        chk("cen_rdy_once", 32'(cpu_rdy), 0);
        tick();

        // Reset in the middle of a DMA write
        dma_addr = 24'h123456; dma_we = 2'b11; dma_dout = 16'hBEEF; dma_req = 1'b1;
        tick();
        chk("rs_gnt", 32'(gnt), 32'(2'b10));
        #2 rst = 1'b0;
        #1;
        chk("rs_we", 32'(mem_we), 0);
        chk("rs_cs", 32'(mem_cs), 0);
        chk("rs_gnt0", 32'(gnt), 0);
        chk("rs_addr", 32'(mem_addr), 0);
        chk("rs_dout", 32'(mem_dout), 0);
        chk("rs_din", 32'({cpu_din, dma_din}), 0);
        dma_req = 1'b0;
        tick();
        rst = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("rs_after_we", 32'(mem_we), 0);
            chk("rs_after_rdy", 32'({cpu_rdy, dma_rdy}), 0);
            chk("rs_after_cs", 32'(mem_cs), 0);
        end
        $display("dma write addr=123456 aborted by reset");

        // Randomized traffic with random cen
        c_act = 1'b0; d_act = 1'b0; c_fin = 1'b0; d_fin = 1'b0;
        c_dm = '0; d_dm = '0; c_age = 0; d_age = 0;
        c_a = '0; d_a = '0; c_w = '0; d_w = '0; c_o = '0; d_o = '0;
        run = 0; owner = 0; we_cnt = 0; prev_gnt = 2'b00;
        for (int it = 0; it < N_RUN + 600; it++) begin
            @(posedge clk); #1;
            e_c = cpu_req; e_d = dma_req; e_cen = cen;
            if (c_fin) begin c_act = 1'b0; c_fin = 1'b0; cpu_req = 1'b0; end
            if (d_fin) begin d_act = 1'b0; d_fin = 1'b0; dma_req = 1'b0; end
            if (!c_act && it < N_RUN && $urandom_range(0, 2) == 0) begin
                c_act = 1'b1; c_age = 0;
                c_a = 24'($urandom);
                c_w = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
                c_o = 16'($urandom);
                cpu_addr = c_a; cpu_we = c_w; cpu_dout = c_o; cpu_req = 1'b1;
            end
            if (!d_act && it < N_RUN && $urandom_range(0, 2) == 0) begin
                d_act = 1'b1; d_age = 0;
                d_a = 24'($urandom);
                d_w = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
                d_o = 16'($urandom);
                dma_addr = d_a; dma_we = d_w; dma_dout = d_o; dma_req = 1'b1;
            end
            cen = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (!cen) begin
                chk("r_cen_lo_we", 32'(mem_we), 0);
                chk("r_cen_lo_rdy", 32'({cpu_rdy, dma_rdy}), 0);
            end
            if (gnt != 2'b00 && prev_gnt == 2'b00) begin
                chk("r_pick_cen", 32'(e_cen), 1);
                chk("r_pick", 32'(gnt), 32'(want_gnt(e_c, e_d, run)));
                we_cnt = 0;
                if (gnt == 2'b01) begin
                    owner = 1; run = 0;
                    chk("r_addr_c", 32'(mem_addr), 32'(c_a));
                    chk("r_dout_c", 32'(mem_dout), 32'(c_o));
                end else begin
                    owner = 2; run = e_c ? run + 1 : 0;
                    chk("r_addr_d", 32'(mem_addr), 32'(d_a));
                    chk("r_dout_d", 32'(mem_dout), 32'(d_o));
                end
            end
            prev_gnt = gnt;
            if (mem_we != 2'b00) begin
                we_cnt++;
                chk("r_we_lanes", 32'(mem_we), 32'((owner == 1) ? c_w : d_w));
            end
            if (cpu_rdy) begin
                chk("r_c_owner", 32'(owner), 1);
                if (c_w == 2'b00) c_dm = mem_word(c_a);
                chk("r_c_we_cnt", 32'(we_cnt), (c_w != 2'b00) ? 1 : 0);
                chk("r_c_din", 32'(cpu_din), 32'(c_dm));
                chk("r_d_din_keep", 32'(dma_din), 32'(d_dm));
                $display("cpu %s addr=%06h data=%04h we=%02b", (c_w == 2'b00) ? "read " : "write",
                         c_a, (c_w == 2'b00) ? cpu_din : c_o, c_w);
                c_fin = 1'b1; owner = 0;
            end
            if (dma_rdy) begin
                chk("r_d_owner", 32'(owner), 2);
                if (d_w == 2'b00) d_dm = mem_word(d_a);
                chk("r_d_we_cnt", 32'(we_cnt), (d_w != 2'b00) ? 1 : 0);
                chk("r_d_din", 32'(dma_din), 32'(d_dm));
                chk("r_c_din_keep", 32'(cpu_din), 32'(c_dm));
                $display("dma %s addr=%06h data=%04h we=%02b", (d_w == 2'b00) ? "read " : "write",
                         d_a, (d_w == 2'b00) ? dma_din : d_o, d_w);
                d_fin = 1'b1; owner = 0;
            end
            if (c_act && !c_fin) c_age++;
            if (d_act && !d_fin) d_age++;
            if (c_age > 300 || d_age > 300) begin
                chk("r_timeout", 32'(c_age > 300 || d_age > 300), 0);
                break;
            end
            if (it >= N_RUN && !c_act && !d_act) break;
        end
        chk("r_drain", 32'({c_act, d_act}), 0);
        chk("r_final_cpu_din", 32'(cpu_din), 32'(c_dm));
        chk("r_final_dma_din", 32'(dma_din), 32'(d_dm));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
